// File: rtl/sw_debounce_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_pkg
// Description : Shared constants and helpers for the sw_debounce_8 switch
//               conditioning stage (default widths, counter-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

   localparam int NBITS_DEF     = 8;
   localparam int DB_CYCLES_DEF = 16;

   // Counter must hold values 0..DB_CYCLES-1; one extra code keeps the
   // formula valid for any legal DB_CYCLES (2..65535).
   function automatic int cnt_width(input int db_cycles);
      return $clog2(db_cycles + 1);
   endfunction

endpackage : sw_pkg
`default_nettype wire

// File: rtl/sw_debounce_8_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_8_if
// Description : Switch-side / encoder-side signal bundle for sw_debounce_8.
//               sw_in  : raw asynchronous switch levels
//               tick   : sample enable for the debounce counters
//               clr    : sticky clear (only meaningful with DEBOUNCE_LATCH_EN)
//               x_out  : debounced vector to the encoder x input
//               chg    : one-cycle pulse when x_out changed
//               busy   : a candidate change is pending on some bit
//               Modport master drives the inputs, slave is the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sw_debounce_8_if
   import sw_pkg::*;
#(
   parameter int NBITS = NBITS_DEF
);
   logic [NBITS-1:0] sw_in;
   logic             tick;
   logic             clr;
   logic [NBITS-1:0] x_out;
   logic             chg;
   logic             busy;

   modport master (
      output sw_in, tick, clr,
      input  x_out, chg, busy
   );

   modport slave (
      input  sw_in, tick, clr,
      output x_out, chg, busy
   );
endinterface : sw_debounce_8_if
`default_nettype wire

// File: rtl/sw_debounce_8_db_bit.sv
`default_nettype none
// ============================================================================
// Module      : db_bit
// Description : Single-bit synchroniser plus debounce counter.
//               clk, rst : clock, synchronous active-high reset
//               tick     : counter advance enable
//               d_in     : raw asynchronous level
//               q        : debounced (stable) level
//               flip     : q changes on the coming clock edge
//               pend     : counter non-zero (candidate change pending)
// Revision    : 1.0 - initial release
// ============================================================================
module db_bit #(
   parameter int DB_CYCLES = 16,
   parameter int CNT_W     = 5
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic tick,
   input  wire logic d_in,
   output logic      q,
   output logic      flip,
   output logic      pend
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(DB_CYCLES - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_mismatch;

   assign w_mismatch = (r_s2 != r_stable);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1     <= 1'b0;
         r_s2     <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_s1 <= d_in;
         r_s2 <= r_s1;
         if (!w_mismatch) begin
            // bounce back to the accepted level restarts qualification
            r_cnt <= '0;
         end else if (tick) begin
            if (r_cnt == c_last) begin
               r_stable <= r_s2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         // tick low with a mismatch: count frozen
      end
   end

   assign q    = r_stable;
   assign flip = w_mismatch && tick && (r_cnt == c_last);
   assign pend = (r_cnt != '0);

endmodule : db_bit
`default_nettype wire

// File: rtl/sw_debounce_8.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_8
// Description : Synchronises and debounces 8 switch levels feeding the 8-to-3
//               priority encoder; flags real changes with a one-cycle chg.
//               clk, rst : clock, synchronous active-high reset
//               bus      : sw_debounce_8_if.slave (sw_in, tick, clr ->
//                          x_out, chg, busy)
//               Build option DEBOUNCE_LATCH_EN: x_out shows sticky bits set
//               by debounced rising edges and cleared by clr.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_8
   import sw_pkg::*;
#(
   parameter int NBITS     = NBITS_DEF,
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input wire logic        clk,
   input wire logic        rst,
   sw_debounce_8_if.slave  bus
);

   localparam int CNT_W = cnt_width(DB_CYCLES);

   logic [NBITS-1:0] w_q;
   logic [NBITS-1:0] w_flip;
   logic [NBITS-1:0] w_pend;
   logic             r_chg;

   generate
      for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
         db_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
         ) u_db_bit (
            .clk  (clk),
            .rst  (rst),
            .tick (bus.tick),
            .d_in (bus.sw_in[gi]),
            .q    (w_q[gi]),
            .flip (w_flip[gi]),
            .pend (w_pend[gi])
         );
      end
   endgenerate

   assign bus.busy = |w_pend;
   assign bus.chg  = r_chg;

`ifdef DEBOUNCE_LATCH_EN
   logic [NBITS-1:0] r_sticky;
   logic [NBITS-1:0] w_set;
   logic [NBITS-1:0] w_sticky_nxt;

   // a flip while the stable level is 0 is a debounced rising edge
   assign w_set = w_flip & ~w_q;

   always_comb begin
      w_sticky_nxt = r_sticky;
      if (bus.clr) begin
         w_sticky_nxt = '0;
      end
      // applied after clr so a coincident set survives
      w_sticky_nxt = w_sticky_nxt | w_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky <= '0;
         r_chg    <= 1'b0;
      end else begin
         r_sticky <= w_sticky_nxt;
         r_chg    <= (w_sticky_nxt != r_sticky);
      end
   end

   assign bus.x_out = r_sticky;
`else
   logic w_unused_clr;
   assign w_unused_clr = bus.clr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_chg <= 1'b0;
      end else begin
         r_chg <= |w_flip;
      end
   end

   assign bus.x_out = w_q;
`endif

endmodule : sw_debounce_8
`default_nettype wire

// File: tb/tb_sw_debounce_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce_8
// Description : Directed self-checking bench for sw_debounce_8
//               (NBITS=8, DB_CYCLES=16). Covers both builds of
//               DEBOUNCE_LATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce_8;

   localparam int c_db = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int n_chg = 0;

   sw_debounce_8_if #(.NBITS(8)) bus ();

   sw_debounce_8 #(
      .NBITS     (8),
      .DB_CYCLES (c_db)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock edge, then settle; counts chg pulses seen
   task automatic step();
      @(posedge clk);
      #1;
      if (bus.chg) n_chg++;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) step();
      rst = 1'b0;
   endtask

   // Input already changed before call; edge k=0 is the first sampling edge.
   // x_out must hold old_v through k=16 and show new_v at k=17 with one chg.
   task automatic latency(input string tag, input logic [7:0] old_v,
                          input logic [7:0] new_v, input logic clr_last);
      n_chg = 0;
      for (int k = 0; k <= 16; k++) step();
      check({tag, "_x_before"}, bus.x_out, old_v);
      check({tag, "_busy_before"}, bus.busy, 1);
      check({tag, "_no_early_chg"}, n_chg, 0);
      bus.clr = clr_last;
      step();
      bus.clr = 1'b0;
      check({tag, "_x_after"}, bus.x_out, new_v);
      check({tag, "_chg"}, bus.chg, 1);
      check({tag, "_busy_after"}, bus.busy, 0);
      step();
      check({tag, "_chg_single"}, bus.chg, 0);
   endtask

   initial begin
      logic saw_busy;
      int   x_bad;

      bus.sw_in = 8'hFF;
      bus.tick  = 1'b1;
      bus.clr   = 1'b0;

      // ---- reset with all switches high ----
      do_reset(3);
      check("rst_x", bus.x_out, 8'h00);
      check("rst_chg", bus.chg, 0);
      check("rst_busy", bus.busy, 0);
      latency("rst_rel", 8'h00, 8'hFF, 1'b0);

      // ---- glitch on bit 3 (10 cycles low) ----
      n_chg = 0; saw_busy = 1'b0; x_bad = 0;
      bus.sw_in = 8'hF7;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus.busy) saw_busy = 1'b1;
         if (bus.x_out != 8'hFF) x_bad++;
      end
      bus.sw_in = 8'hFF;
      for (int k = 0; k < 20; k++) begin
         step();
         if (bus.busy) saw_busy = 1'b1;
         if (bus.x_out != 8'hFF) x_bad++;
      end
      check("glitch_x_stable", x_bad, 0);
      check("glitch_no_chg", n_chg, 0);
      check("glitch_busy_seen", saw_busy, 1);
      check("glitch_busy_idle", bus.busy, 0);

      // ---- bounce on bit 7, then settle high ----
      bus.sw_in = 8'h00;
      do_reset(2);
      n_chg = 0;
      for (int t = 0; t < 4; t++) begin
         bus.sw_in = (t % 2 == 0) ? 8'h80 : 8'h00;
         repeat (3) step();
      end
      check("bounce_x_quiet", bus.x_out, 8'h00);
      check("bounce_no_chg", n_chg, 0);
      bus.sw_in = 8'h80;
      latency("bounce", 8'h00, 8'h80, 1'b0);

      // ---- tick every 4th edge, step on bit 0 ----
      bus.sw_in = 8'h00;
      do_reset(2);
      n_chg = 0;
      bus.sw_in = 8'h01;
      for (int k = 0; k <= 62; k++) begin
         bus.tick = (k % 4 == 3);
         step();
         if (k == 4) check("tick_hold_busy", bus.busy, 1);
      end
      check("tick_x_before", bus.x_out, 8'h00);
      check("tick_busy_before", bus.busy, 1);
      check("tick_no_early_chg", n_chg, 0);
      bus.tick = 1'b1;          // edge 63 is the 16th tick edge
      step();
      check("tick_x_after", bus.x_out, 8'h01);
      check("tick_chg", bus.chg, 1);

      // ---- two bits, reset at count 8 ----
      bus.sw_in = 8'h00;
      do_reset(2);
      bus.sw_in = 8'h81;
      for (int k = 0; k <= 9; k++) step();
      check("mid_busy_pending", bus.busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_x", bus.x_out, 8'h00);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_chg", bus.chg, 0);
      latency("mid_rel", 8'h00, 8'h81, 1'b0);

      // ---- bit 2 press / release / clr ----
      bus.sw_in = 8'h00;
      do_reset(2);
      bus.sw_in = 8'h04;
      latency("press", 8'h00, 8'h04, 1'b0);
      bus.sw_in = 8'h00;
`ifdef DEBOUNCE_LATCH_EN
      n_chg = 0;
      repeat (20) step();
      check("release_sticky_x", bus.x_out, 8'h04);
      check("release_sticky_no_chg", n_chg, 0);
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      check("clr_x", bus.x_out, 8'h00);
      check("clr_chg", bus.chg, 1);
`else
      latency("release", 8'h04, 8'h00, 1'b0);
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      check("clr_ignored_x", bus.x_out, 8'h00);
      check("clr_ignored_chg", bus.chg, 0);
`endif
      bus.sw_in = 8'h04;
      latency("set_with_clr", 8'h00, 8'h04, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sw_debounce_8
`default_nettype wire
